softmax_normalizer: RTL and testbench

- Back end of the pseudo-softmax datapath. Consumes one frame: the FLP sum {exp, mant} produced by the FLP adder tree, plus the same NUM_INPUTS log-domain inputs that fed the tree.
- Converts the sum to log2 fixed point (Mitchell approximation) and subtracts it from each input.
- Streams the NUM_INPUTS normalized results out serially, one per accepted valid/ready handshake.

---
 rtl/softmax_normalizer.sv | 222 ++++++++++++++++++++++
 tb/tb_softmax_normalizer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/softmax_normalizer.sv
// softmax_normalizer
// Back end of the pseudo-softmax datapath. Takes one frame (the floating-point
// sum {exp, mant} from the adder tree plus the NUM_INPUTS log-domain inputs
// that fed it). The sum is turned into log2 fixed point with the Mitchell
// approximation and subtracted from each input. The normalized elements then
// stream out one per valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    frame handshake
//   input_bus              NUM_INPUTS signed Q(MANT_WIDTH-FRAC_BITS).FRAC_BITS elements
//   exp, mant              sum = (1 + mant/2^MANT_WIDTH) * 2^exp, exp signed
//   out_valid / out_ready  element handshake
//   out_data               normalized element
//   out_index              element index of out_data
//   out_last               high with element NUM_INPUTS-1
//
// Optional build macro SOFTMAX_EXP2_OUT_EN: out_data becomes the linear
// probability 2^y as unsigned Q0.MANT_WIDTH, at the cost of one extra
// pipeline stage ahead of the output register.

module softmax_normalizer #(
   parameter int NUM_INPUTS = 10,
   parameter int EXP_WIDTH  = 9,
   parameter int MANT_WIDTH = 8,
   parameter int FRAC_BITS  = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [NUM_INPUTS*MANT_WIDTH-1:0]   input_bus,
   input  logic [EXP_WIDTH-1:0]               exp,
   input  logic [MANT_WIDTH-1:0]              mant,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [MANT_WIDTH-1:0]              out_data,
   output logic [$clog2(NUM_INPUTS)-1:0]      out_index,
   output logic                               out_last
);

   localparam int IDX_W = $clog2(NUM_INPUTS);
   localparam int WIDE  = EXP_WIDTH + FRAC_BITS + 2;
   localparam int MW1   = MANT_WIDTH + 1;
   localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_INPUTS - 1);
   localparam logic signed [WIDE-1:0] SAT_HI   = WIDE'((1 << (MANT_WIDTH - 1)) - 1);
   localparam logic signed [WIDE-1:0] SAT_LO   = WIDE'(-(1 << (MANT_WIDTH - 1)));

   typedef enum logic [1:0] {IDLE, CALC, PRIME, STREAM} state_e;

   state_e                    state_q, state_d;
   logic [MANT_WIDTH-1:0]     elem_q [NUM_INPUTS];
   logic signed [EXP_WIDTH-1:0] exp_q;
   logic [MANT_WIDTH-1:0]     mant_q;
   logic                      frameLoad;
   logic signed [WIDE-1:0]    log_fx_q, log_fx_d, logNow;
   logic                      in_ready_q, in_ready_d;
   logic                      out_valid_q, out_valid_d;
   logic [MANT_WIDTH-1:0]     out_data_q, out_data_d;
   logic [IDX_W-1:0]          out_index_q, out_index_d;
   logic                      out_last_q, out_last_d;
   logic [IDX_W-1:0]          nextIdx;
`ifdef SOFTMAX_EXP2_OUT_EN
   logic [MANT_WIDTH-1:0]     y_q, y_d;
`endif

   // Mitchell log2 of the sum: the exponent is the integer part and the top
   // FRAC_BITS of the mantissa fraction stand in for log2(1 + m).
   function automatic logic signed [WIDE-1:0] logOf(input logic signed [EXP_WIDTH-1:0] e,
                                                    input logic [MANT_WIDTH-1:0] m);
      logic signed [WIDE-1:0] eExt;
      logic [MANT_WIDTH-1:0]  mTop;
      eExt = WIDE'(e);
      mTop = m >> (MANT_WIDTH - FRAC_BITS);
      return (eExt <<< FRAC_BITS) + signed'(WIDE'(mTop));
   endfunction

   // Element minus log-sum, clipped to the signed element range.
   function automatic logic [MANT_WIDTH-1:0] satDiff(input logic [MANT_WIDTH-1:0] x,
                                                     input logic signed [WIDE-1:0] lg);
      logic signed [WIDE-1:0] d;
      d = WIDE'(signed'(x)) - lg;
      if (d > SAT_HI) d = SAT_HI;
      else if (d < SAT_LO) d = SAT_LO;
      return d[MANT_WIDTH-1:0];
   endfunction

`ifdef SOFTMAX_EXP2_OUT_EN
   // 2^y for a non-positive log value: the fractional part is linearised as
   // (1 + f) and the negative integer part becomes a right shift. Any y >= 0
   // means a probability of one, which pins to full scale.
   function automatic logic [MANT_WIDTH-1:0] exp2Of(input logic [MANT_WIDTH-1:0] y);
      logic signed [MANT_WIDTH-1:0] iPart;
      logic [MANT_WIDTH-1:0]        shAmt;
      logic [MW1-1:0]               scaled;
      iPart = signed'(y) >>> FRAC_BITS;
      if (!iPart[MANT_WIDTH-1]) return '1;
      scaled = MW1'({1'b1, y[FRAC_BITS-1:0]}) << (MANT_WIDTH - FRAC_BITS);
      shAmt  = -iPart;
      return MANT_WIDTH'(scaled >> shAmt);
   endfunction
`endif

   // Next-state and next-output logic. Every output is loaded into a register
   // here one cycle ahead, so nothing downstream sees a combinational path
   // from in_valid or out_ready. While STREAM is stalled the defaults hold
   // data, index and last steady.
   always_comb begin
      state_d     = state_q;
      frameLoad   = 1'b0;
      log_fx_d    = log_fx_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      nextIdx     = out_index_q + IDX_W'(1);
      logNow      = logOf(exp_q, mant_q);
`ifdef SOFTMAX_EXP2_OUT_EN
      y_d         = y_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               frameLoad  = 1'b1;
               in_ready_d = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            log_fx_d = logNow;
`ifdef SOFTMAX_EXP2_OUT_EN
            y_d      = satDiff(elem_q[0], logNow);
            state_d  = PRIME;
`else
            out_data_d  = satDiff(elem_q[0], logNow);
            out_index_d = '0;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = STREAM;
`endif
         end
`ifdef SOFTMAX_EXP2_OUT_EN
         // Fill the second stage: element 0 moves to the output while the
         // log value of element 1 is prefetched behind it.
         PRIME: begin
            out_data_d  = exp2Of(y_q);
            out_index_d = '0;
            out_last_d  = 1'b0;
            out_valid_d = 1'b1;
            y_d         = satDiff(elem_q[1], log_fx_q);
            state_d     = STREAM;
         end
`endif
         STREAM: begin
            if (out_valid_q && out_ready) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  in_ready_d  = 1'b1;
                  state_d     = IDLE;
               end else begin
                  out_index_d = nextIdx;
                  out_last_d  = (nextIdx == LAST_IDX);
`ifdef SOFTMAX_EXP2_OUT_EN
                  out_data_d  = exp2Of(y_q);
                  if (nextIdx != LAST_IDX)
                     y_d = satDiff(elem_q[nextIdx + IDX_W'(1)], log_fx_q);
`else
                  out_data_d  = satDiff(elem_q[nextIdx], log_fx_q);
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, frame and output registers. The frame is captured only on the
   // input handshake, so a held in_valid during CALC/STREAM is ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         exp_q       <= '0;
         mant_q      <= '0;
         log_fx_q    <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
         for (int k = 0; k < NUM_INPUTS; k++) elem_q[k] <= '0;
`ifdef SOFTMAX_EXP2_OUT_EN
         y_q         <= '0;
`endif
      end else begin
         state_q     <= state_d;
         log_fx_q    <= log_fx_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
`ifdef SOFTMAX_EXP2_OUT_EN
         y_q         <= y_d;
`endif
         if (frameLoad) begin
            exp_q  <= exp;
            mant_q <= mant;
            for (int k = 0; k < NUM_INPUTS; k++)
               elem_q[k] <= input_bus[k*MANT_WIDTH +: MANT_WIDTH];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_softmax_normalizer.sv
// tb_softmax_normalizer
// Directed bench for softmax_normalizer with default parameters
// (10 elements, Q4.4, 9-bit exponent). Expected outputs are hand-computed
// constants for both the log-domain build and the SOFTMAX_EXP2_OUT_EN build.

module tb_softmax_normalizer;

   localparam int NUM = 10;
`ifdef SOFTMAX_EXP2_OUT_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [79:0] input_bus;
   logic [8:0]  sumExp;
   logic [7:0]  sumMant;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [3:0]  out_index;
   logic        out_last;

   int          nAsserts = 0;
   int          nFails   = 0;
   logic [7:0]  expD [NUM];

   softmax_normalizer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .input_bus (input_bus),
      .exp       (sumExp),
      .mant      (sumMant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index),
      .out_last  (out_last)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just past the rising edge, where inputs are
   // driven and registered outputs are sampled.
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One counted comparison.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Present a frame, complete the input handshake and wait out the CALC
   // latency so the first element should be on the output afterwards.
   task automatic applyStimulus(input logic [79:0] bus, input logic [8:0] e,
                                input logic [7:0] m);
      input_bus = bus;
      sumExp    = e;
      sumMant   = m;
      in_valid  = 1'b1;
      checkOutput("acceptReady", in_ready, 1);
      step;
      checkOutput("calcBusy", in_ready, 0);
      checkOutput("calcNoValid", out_valid, 0);
      in_valid = 1'b0;
      repeat (LAT) step;
   endtask

   // Drain nWanted elements against expD. Optionally stalls 3 cycles at
   // element bpAt and checks that in_ready stays low while a new frame is
   // offered on the input.
   task automatic receiveFrame(input int nWanted, input int bpAt, input bit holdNew);
      int received = 0;
      int guard    = 0;
      bit bpDone   = 1'b0;
      while (received < nWanted && guard < 200) begin
         guard++;
         if (holdNew) checkOutput("blockedReady", in_ready, 0);
         checkOutput("streamValid", out_valid, 1);
         if (out_valid !== 1'b1) begin
            step;
         end else begin
            if (!bpDone && received == bpAt) begin
               out_ready = 1'b0;
               repeat (3) begin
                  step;
                  checkOutput("bpValid", out_valid, 1);
                  checkOutput("bpIndex", out_index, bpAt);
                  checkOutput("bpData", out_data, expD[bpAt]);
               end
               out_ready = 1'b1;
               bpDone    = 1'b1;
            end
            checkOutput("index", out_index, received);
            checkOutput("data", out_data, expD[received]);
            checkOutput("last", out_last, received == NUM - 1);
            received++;
            step;
         end
      end
      checkOutput("transfers", received, nWanted);
   endtask

   // After a full frame the block must be back in IDLE with no output.
   task automatic checkIdle;
      checkOutput("idleReady", in_ready, 1);
      checkOutput("idleValid", out_valid, 0);
      checkOutput("idleLast", out_last, 0);
   endtask

   // Directed sequence: reset, uniform frame with backpressure, saturation
   // frame with a blocked second frame, the second frame, then reset
   // mid-stream.
   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      input_bus = '0;
      sumExp    = '0;
      sumMant   = '0;

      repeat (2) step;
      checkOutput("rstReady", in_ready, 1);
      checkOutput("rstValid", out_valid, 0);
      checkOutput("rstData", out_data, 0);
      checkOutput("rstIndex", out_index, 0);
      checkOutput("rstLast", out_last, 0);
      rst_n = 1'b1;
      step;
      checkOutput("relReady", in_ready, 1);
      checkOutput("relValid", out_valid, 0);

      // Uniform frame: log_fx = 3*16 + 4 = 52, each output 0 - 52 = 0xCC.
`ifdef SOFTMAX_EXP2_OUT_EN
      expD = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C};
`else
      expD = '{8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
`endif
      $display("[TB] uniform frame with backpressure at index 4");
      out_ready = 1'b1;
      applyStimulus(80'h0, 9'd3, 8'd64);
      receiveFrame(NUM, 4, 1'b0);
      checkIdle;

      // Saturation: log_fx = -160; 0x7F+160 clips to 0x7F, 0x80+160 = 0x20,
      // zero elements give 160 which clips to 0x7F.
`ifdef SOFTMAX_EXP2_OUT_EN
      expD = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
      expD = '{8'h7F, 8'h20, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
`endif
      $display("[TB] saturation frame with a second frame offered during stream");
      applyStimulus({64'h0, 8'h80, 8'h7F}, 9'h1F6, 8'd0);
      input_bus = {8'd72, 8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8, 8'd0};
      sumExp    = 9'd3;
      sumMant   = 8'd64;
      in_valid  = 1'b1;
      receiveFrame(NUM, -1, 1'b1);
      checkIdle;

      // Second frame: element k = 8k, log_fx = 52, outputs 8k - 52.
`ifdef SOFTMAX_EXP2_OUT_EN
      expD = '{8'd28, 8'd40, 8'd56, 8'd80, 8'd112, 8'd160, 8'd224, 8'd255, 8'd255, 8'd255};
`else
      expD = '{8'hCC, 8'hD4, 8'hDC, 8'hE4, 8'hEC, 8'hF4, 8'hFC, 8'h04, 8'h0C, 8'h14};
`endif
      $display("[TB] second frame accepted after return to IDLE");
      applyStimulus({8'd72, 8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8, 8'd0},
                    9'd3, 8'd64);
      receiveFrame(NUM, -1, 1'b0);
      checkIdle;

      // Reset while element 5 of a uniform frame is on the output.
`ifdef SOFTMAX_EXP2_OUT_EN
      expD = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C};
`else
      expD = '{8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
`endif
      $display("[TB] reset mid-stream at index 5");
      applyStimulus(80'h0, 9'd3, 8'd64);
      receiveFrame(5, -1, 1'b0);
      checkOutput("midIndex", out_index, 5);
      checkOutput("midValid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncValid", out_valid, 0);
      checkOutput("asyncReady", in_ready, 1);
      checkOutput("asyncIndex", out_index, 0);
      checkOutput("asyncData", out_data, 0);
      step;
      rst_n = 1'b1;
      repeat (3) step;
      checkOutput("postValid", out_valid, 0);
      checkOutput("postReady", in_ready, 1);
      checkOutput("postData", out_data, 0);
      checkOutput("postLast", out_last, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
